lbuf_rd_timing: RTL and testbench
=================================

LBUF_RD_TIMING -- requirements
Module: lbuf_rd_timing

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, output pixels per line.
REQ-002 SHALL have parameter H_ACTIVE, default 640, active output pixels per line.
REQ-003 SHALL have parameter H_SYNCLEN, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_AVIDSTART, default 144, first active pixel index.
REQ-005 SHALL have parameters V_TOTAL/V_ACTIVE/V_SYNCLEN/V_AVIDSTART, defaults 525/480/2/35, vertical equivalents in lines.
REQ-006 SHALL have parameter LBUF_LINES, default 40, line-buffer ring depth.
REQ-007 SHALL have parameter V_LOCK_LINE, default 0, vcnt value loaded on frame lock.
REQ-008 SHALL use one clock and an asynchronous active-low reset: PCLK_ext  input  1  output pixel clock; reset_n  input  1  async active-low reset.
REQ-009 SHALL have port frame_start  input  1  one-cycle pulse, input frame begun, already synchronous to PCLK_ext.
REQ-010 SHALL have ports hcnt_ext  output  11  and vcnt_ext  output  11  for the output pixel and line counters.
REQ-011 SHALL have port hcnt_ext_lbuf  output  9  for the source pixel read address.
REQ-012 SHALL have port vcnt_ext_lbuf  output  6  for the line-buffer ring index.
REQ-013 SHALL have ports HSYNC_ext, VSYNC_ext  output  1 each; active-low syncs.
REQ-014 SHALL have port DE_ext  output  1  for data enable.
REQ-015 SHALL have port vlock_adj  output  1  one-cycle pulse when a lock changed vcnt.

Function
REQ-016 SHALL register all outputs; HSYNC_ext/VSYNC_ext/DE_ext/lbuf addresses SHALL correspond to the hcnt_ext/vcnt_ext values in the same cycle.
REQ-017 SHALL increment hcnt_ext each cycle and wrap H_TOTAL-1->0; vcnt_ext SHALL increment on each hcnt wrap and wrap V_TOTAL-1->0.
REQ-018 SHALL drive HSYNC_ext=0 iff hcnt_ext<H_SYNCLEN and VSYNC_ext=0 iff vcnt_ext<V_SYNCLEN.
REQ-019 SHALL drive DE_ext=1 iff H_AVIDSTART<=hcnt_ext<H_AVIDSTART+H_ACTIVE and V_AVIDSTART<=vcnt_ext<V_AVIDSTART+V_ACTIVE.
REQ-020 SHALL set hcnt_ext_lbuf=floor(3*x/5), x=hcnt_ext-H_AVIDSTART, during horizontal active; computation SHALL use an incremental mod-5 accumulator (add 3; on >=5 subtract 5 and step address), not a multiplier or divider.
REQ-021 SHALL hold hcnt_ext_lbuf=0 outside horizontal active; x=639 SHALL yield 383.
REQ-022 SHALL load vcnt_ext_lbuf=0 and clear the pair bit on entering vcnt_ext=V_AVIDSTART.
REQ-023 SHALL toggle the pair bit on each later active-line entry and, when pair was 1, advance vcnt_ext_lbuf, wrapping LBUF_LINES-1->0, giving 2x line repeat.
REQ-024 SHALL hold vcnt_ext_lbuf outside vertical active.

Reset
REQ-025 SHALL force on reset_n low: hcnt_ext=0, vcnt_ext=0, hcnt_ext_lbuf=0, vcnt_ext_lbuf=0, HSYNC_ext=0, VSYNC_ext=0, DE_ext=0, vlock_adj=0, accumulator=0, pair=0, lock pending=0.
REQ-026 SHALL start counting on the first PCLK_ext edge after reset release; a frame_start pulse during reset SHALL be ignored.

Configuration
REQ-027 SHALL implement frame lock only when macro FRAME_LOCK_EN is defined.
REQ-028 SHALL, with FRAME_LOCK_EN defined, set lock pending on frame_start; at the next hcnt wrap load vcnt_ext=V_LOCK_LINE instead of incrementing, clear pending, and pulse vlock_adj only if the increment result differed.
REQ-029 SHALL, with FRAME_LOCK_EN defined, apply a frame_start coincident with an hcnt wrap at that wrap; a second pulse while pending SHALL be absorbed.
REQ-030 SHALL, without FRAME_LOCK_EN, free-run, ignore frame_start, and tie vlock_adj=0.

Structure
REQ-031 SHALL place default timing constants (the 640x480 set, LBUF_LINES, CPS2 active width 384) in shared package sc_timing_pkg.
REQ-032 SHALL put the 3/5 accumulator in sub-module lbuf_hscaler.

Verification
REQ-033 SHALL test reset release and 800 cycles: HSYNC_ext low for hcnt 0..95; DE_ext first high at hcnt 144, vcnt 35.
REQ-034 SHALL test one active line: hcnt_ext_lbuf sequence 0,0,1,1,2,3 at x=0..5; 383 at x=639; 0 at hcnt 784.
REQ-035 SHALL test a full frame: vcnt_ext_lbuf 0 on lines 35,36; 1 on 37,38; wraps 39->0 at line 115; 525 lines per frame.
REQ-036 SHALL test FRAME_LOCK_EN with frame_start at vcnt 300, hcnt 10: vcnt_ext=0 after next wrap and vlock_adj pulses once.
REQ-037 SHALL test FRAME_LOCK_EN with frame_start at hcnt 799 and vcnt 524: vcnt_ext->0 and no vlock_adj pulse.
REQ-038 SHALL test without FRAME_LOCK_EN: frame_start pulses give no change to counters and vlock_adj stays 0.

Source files
------------

// File: rtl/sc_timing_pkg.sv
// Shared 640x480 output timing constants and line-buffer geometry used by the
// line-buffer read timing generator and its horizontal scaler.
package sc_timing_pkg;

  localparam int SC_H_TOTAL     = 800;
  localparam int SC_H_ACTIVE    = 640;
  localparam int SC_H_SYNCLEN   = 96;
  localparam int SC_H_AVIDSTART = 144;

  localparam int SC_V_TOTAL     = 525;
  localparam int SC_V_ACTIVE    = 480;
  localparam int SC_V_SYNCLEN   = 2;
  localparam int SC_V_AVIDSTART = 35;

  localparam int SC_LBUF_LINES  = 40;
  localparam int SC_CPS2_H_ACTIVE = 384;

  localparam int SC_CNT_W   = 11;
  localparam int SC_HADDR_W = 9;
  localparam int SC_VADDR_W = 6;

  typedef logic [SC_CNT_W-1:0]   cnt_t;
  typedef logic [SC_HADDR_W-1:0] haddr_t;
  typedef logic [SC_VADDR_W-1:0] vaddr_t;

  // 3/5 scaling: the accumulator steps by NUM and rolls over at DEN.
  localparam logic [3:0] SC_SCALE_NUM = 4'd3;
  localparam logic [3:0] SC_SCALE_DEN = 4'd5;

endpackage

// File: rtl/lbuf_hscaler.sv
// Source pixel address generator: maps output pixel x to floor(3*x/5) with a
// mod-5 accumulator, restarting on i_start and parking at zero when inactive.
module lbuf_hscaler
  import sc_timing_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_start,
  input  logic   i_active,
  output haddr_t o_addr
);

  logic [2:0] r_acc;
  haddr_t     r_addr;
  logic [3:0] w_sum;

  assign w_sum  = {1'b0, r_acc} + SC_SCALE_NUM;
  assign o_addr = r_addr;

  // i_start/i_active describe the pixel being loaded, so r_addr lines up with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc  <= '0;
      r_addr <= '0;
    end else if (i_start) begin
      r_acc  <= '0;
      r_addr <= '0;
    end else if (i_active) begin
      if (w_sum >= SC_SCALE_DEN) begin
        r_acc  <= 3'(w_sum - SC_SCALE_DEN);
        r_addr <= r_addr + 9'd1;
      end else begin
        r_acc  <= w_sum[2:0];
      end
    end else begin
      r_acc  <= '0;
      r_addr <= '0;
    end
  end

endmodule

// File: rtl/lbuf_rd_timing.sv
// Output raster timing with line-buffer read addressing (3/5 horizontal, 2x
// vertical). Optional frame lock to an input frame_start under FRAME_LOCK_EN.
module lbuf_rd_timing
  import sc_timing_pkg::*;
#(
  parameter int H_TOTAL     = SC_H_TOTAL,
  parameter int H_ACTIVE    = SC_H_ACTIVE,
  parameter int H_SYNCLEN   = SC_H_SYNCLEN,
  parameter int H_AVIDSTART = SC_H_AVIDSTART,
  parameter int V_TOTAL     = SC_V_TOTAL,
  parameter int V_ACTIVE    = SC_V_ACTIVE,
  parameter int V_SYNCLEN   = SC_V_SYNCLEN,
  parameter int V_AVIDSTART = SC_V_AVIDSTART,
  parameter int LBUF_LINES  = SC_LBUF_LINES,
  parameter int V_LOCK_LINE = 0
) (
  input  logic        PCLK_ext,
  input  logic        reset_n,
  input  logic        frame_start,
  output logic [10:0] hcnt_ext,
  output logic [10:0] vcnt_ext,
  output logic [8:0]  hcnt_ext_lbuf,
  output logic [5:0]  vcnt_ext_lbuf,
  output logic        HSYNC_ext,
  output logic        VSYNC_ext,
  output logic        DE_ext,
  output logic        vlock_adj
);

  localparam cnt_t   L_H_LAST  = cnt_t'(H_TOTAL - 1);
  localparam cnt_t   L_H_SYNC  = cnt_t'(H_SYNCLEN);
  localparam cnt_t   L_HA_S    = cnt_t'(H_AVIDSTART);
  localparam cnt_t   L_HA_E    = cnt_t'(H_AVIDSTART + H_ACTIVE);
  localparam cnt_t   L_V_LAST  = cnt_t'(V_TOTAL - 1);
  localparam cnt_t   L_V_SYNC  = cnt_t'(V_SYNCLEN);
  localparam cnt_t   L_VA_S    = cnt_t'(V_AVIDSTART);
  localparam cnt_t   L_VA_E    = cnt_t'(V_AVIDSTART + V_ACTIVE);
  localparam cnt_t   L_V_LOCK  = cnt_t'(V_LOCK_LINE);
  localparam vaddr_t L_LB_LAST = vaddr_t'(LBUF_LINES - 1);

  cnt_t   r_hcnt, r_vcnt;
  vaddr_t r_vbuf;
  logic   r_pair, r_hsync, r_vsync, r_de;

  cnt_t   w_h_nxt, w_v_nxt, w_v_inc;
  logic   w_h_wrap, w_h_act_n, w_v_act_n, w_lock_hit;
  haddr_t w_hbuf;

`ifdef FRAME_LOCK_EN
  logic r_lock_pend, r_vlock_adj;
`endif

  // Everything is computed from the next counter values so that each
  // registered output matches the counters it is presented with.
  always_comb begin
    w_h_wrap   = (r_hcnt == L_H_LAST);
    w_h_nxt    = w_h_wrap ? '0 : r_hcnt + 11'd1;
    w_v_inc    = (r_vcnt == L_V_LAST) ? '0 : r_vcnt + 11'd1;
    w_lock_hit = 1'b0;
`ifdef FRAME_LOCK_EN
    w_lock_hit = w_h_wrap && (r_lock_pend || frame_start);
`endif
    if (!w_h_wrap)       w_v_nxt = r_vcnt;
    else if (w_lock_hit) w_v_nxt = L_V_LOCK;
    else                 w_v_nxt = w_v_inc;
    w_h_act_n = (w_h_nxt >= L_HA_S) && (w_h_nxt < L_HA_E);
    w_v_act_n = (w_v_nxt >= L_VA_S) && (w_v_nxt < L_VA_E);
  end

  always_ff @(posedge PCLK_ext or negedge reset_n) begin
    if (!reset_n) begin
      r_hcnt  <= '0;
      r_vcnt  <= '0;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
      r_de    <= 1'b0;
    end else begin
      r_hcnt  <= w_h_nxt;
      r_vcnt  <= w_v_nxt;
      r_hsync <= (w_h_nxt >= L_H_SYNC);
      r_vsync <= (w_v_nxt >= L_V_SYNC);
      r_de    <= w_h_act_n && w_v_act_n;
    end
  end

  // Each buffered line is shown twice; pair marks the second showing.
  always_ff @(posedge PCLK_ext or negedge reset_n) begin
    if (!reset_n) begin
      r_vbuf <= '0;
      r_pair <= 1'b0;
    end else if (w_h_wrap && w_v_act_n) begin
      if (w_v_nxt == L_VA_S) begin
        r_vbuf <= '0;
        r_pair <= 1'b0;
      end else begin
        r_pair <= ~r_pair;
        if (r_pair) r_vbuf <= (r_vbuf == L_LB_LAST) ? '0 : r_vbuf + 6'd1;
      end
    end
  end

`ifdef FRAME_LOCK_EN
  // A pulse arriving while a lock is pending merges into that lock.
  always_ff @(posedge PCLK_ext or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_pend <= 1'b0;
      r_vlock_adj <= 1'b0;
    end else begin
      r_vlock_adj <= w_lock_hit && (w_v_inc != L_V_LOCK);
      if (w_lock_hit)       r_lock_pend <= 1'b0;
      else if (frame_start) r_lock_pend <= 1'b1;
    end
  end

  assign vlock_adj = r_vlock_adj;
`else
  logic w_unused_frame_start;
  assign w_unused_frame_start = frame_start;
  assign vlock_adj = 1'b0;
`endif

  lbuf_hscaler u_hscaler (
    .i_clk    (PCLK_ext),
    .i_rst_n  (reset_n),
    .i_start  (w_h_nxt == L_HA_S),
    .i_active (w_h_act_n),
    .o_addr   (w_hbuf)
  );

  assign hcnt_ext      = r_hcnt;
  assign vcnt_ext      = r_vcnt;
  assign hcnt_ext_lbuf = w_hbuf;
  assign vcnt_ext_lbuf = r_vbuf;
  assign HSYNC_ext     = r_hsync;
  assign VSYNC_ext     = r_vsync;
  assign DE_ext        = r_de;

endmodule

// File: tb/tb_lbuf_rd_timing.sv
// Directed bench for lbuf_rd_timing: a default-timing instance for line checks
// and a short-line instance so whole frames and frame-lock cases fit in time.
module tb_lbuf_rd_timing;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_a, rst_b, fs_a, fs_b;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] b_hcnt, b_vcnt, s_hcnt, s_vcnt;
  logic [8:0]  b_hbuf, s_hbuf;
  logic [5:0]  b_vbuf, s_vbuf;
  logic        b_hs, b_vs, b_de, b_vl, s_hs, s_vs, s_de, s_vl;

  lbuf_rd_timing u_big (
    .PCLK_ext(clk), .reset_n(rst_a), .frame_start(fs_a),
    .hcnt_ext(b_hcnt), .vcnt_ext(b_vcnt), .hcnt_ext_lbuf(b_hbuf), .vcnt_ext_lbuf(b_vbuf),
    .HSYNC_ext(b_hs), .VSYNC_ext(b_vs), .DE_ext(b_de), .vlock_adj(b_vl)
  );

  // 20-pixel lines: active x=0..9 at hcnt 6..15, vertical timing unchanged.
  lbuf_rd_timing #(.H_TOTAL(20), .H_ACTIVE(10), .H_SYNCLEN(3), .H_AVIDSTART(6)) u_sml (
    .PCLK_ext(clk), .reset_n(rst_b), .frame_start(fs_b),
    .hcnt_ext(s_hcnt), .vcnt_ext(s_vcnt), .hcnt_ext_lbuf(s_hbuf), .vcnt_ext_lbuf(s_vbuf),
    .HSYNC_ext(s_hs), .VSYNC_ext(s_vs), .DE_ext(s_de), .vlock_adj(s_vl)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic bit at_pos(input bit sml, input int v, input int h);
    if (sml) return (s_vcnt == 11'(v)) && (s_hcnt == 11'(h));
    return (b_vcnt == 11'(v)) && (b_hcnt == 11'(h));
  endfunction

  task automatic wait_pos(input bit sml, input int v, input int h, input int budget);
    int n = 0;
    while (!at_pos(sml, v, h) && n < budget) begin
      step();
      n++;
    end
    if (!at_pos(sml, v, h)) begin
      total++;
      bad++;
      $error("FAIL wait_timeout: position v=%0d h=%0d not reached in %0d cycles", v, h, budget);
    end
  endtask

  task automatic pulse_fs_b();
    fs_b = 1'b1;
    step();
    fs_b = 1'b0;
  endtask

  task automatic count_vlock(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      n += int'(s_vl);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int cyc0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    fs_a  = 1'b1;
    fs_b  = 1'b1;
    repeat (3) step();

    check("rst_hcnt", b_hcnt, 0);
    check("rst_vcnt", b_vcnt, 0);
    check("rst_hbuf", b_hbuf, 0);
    check("rst_vbuf", b_vbuf, 0);
    check("rst_hsync", b_hs, 0);
    check("rst_vsync", b_vs, 0);
    check("rst_de", b_de, 0);
    check("rst_vlock", b_vl, 0);
    check("rst_s_vlock", s_vl, 0);
    fs_a = 1'b0;
    fs_b = 1'b0;

    // first line after release on the default-timing instance
    @(negedge clk);
    rst_a = 1'b1;
    for (int k = 1; k <= 800; k++) begin
      step();
      check("line0_hcnt", b_hcnt, k % 800);
      check("line0_vcnt", b_vcnt, k / 800);
      check("line0_hsync", b_hs, ((k % 800) >= 96) ? 1 : 0);
      check("line0_de", b_de, 0);
    end

    wait_pos(0, 34, 144, 30000);
    check("de_v34_h144", b_de, 0);
    wait_pos(0, 35, 143, 1000);
    check("de_v35_h143", b_de, 0);
    check("vbuf_line35", b_vbuf, 0);
    step();
    check("de_first_hcnt", b_hcnt, 144);
    check("de_first", b_de, 1);
    check("hbuf_x0", b_hbuf, 0);
    exp_q = {32'd0, 32'd1, 32'd1, 32'd2, 32'd3};
    for (int x = 1; x <= 5; x++) begin
      step();
      check("hbuf_x1_5", b_hbuf, exp_q.pop_front());
    end
    wait_pos(0, 35, 783, 1000);
    check("hbuf_x639", b_hbuf, 383);
    check("de_x639", b_de, 1);
    step();
    check("hbuf_h784", b_hbuf, 0);
    check("de_h784", b_de, 0);
    check("big_vlock_idle", b_vl, 0);

    // full frame on the short-line instance
    @(negedge clk);
    rst_b = 1'b1;
    cyc0 = cyc;
    wait_pos(1, 1, 5, 100);
    check("vsync_v1", s_vs, 0);
    wait_pos(1, 2, 0, 100);
    check("vsync_v2", s_vs, 1);
    wait_pos(1, 35, 0, 1000);
    check("s_vbuf_35", s_vbuf, 0);
    check("s_hsync_h0", s_hs, 0);
    wait_pos(1, 35, 6, 100);
    check("s_de_h6", s_de, 1);
    check("s_hbuf_x0", s_hbuf, 0);
    wait_pos(1, 35, 15, 100);
    check("s_hbuf_x9", s_hbuf, 5);
    step();
    check("s_de_h16", s_de, 0);
    check("s_hbuf_h16", s_hbuf, 0);
    wait_pos(1, 36, 0, 100);
    check("s_vbuf_36", s_vbuf, 0);
    wait_pos(1, 37, 0, 100);
    check("s_vbuf_37", s_vbuf, 1);
    wait_pos(1, 38, 0, 100);
    check("s_vbuf_38", s_vbuf, 1);
    wait_pos(1, 114, 0, 2000);
    check("s_vbuf_114", s_vbuf, 39);
    wait_pos(1, 115, 0, 100);
    check("s_vbuf_115", s_vbuf, 0);
    wait_pos(1, 520, 0, 9000);
    check("s_vbuf_hold520", s_vbuf, 39);
    wait_pos(1, 524, 19, 200);
    step();
    check("frame_wrap_vcnt", s_vcnt, 0);
    check("frame_wrap_hcnt", s_hcnt, 0);
    check("frame_len", cyc - cyc0, 10500);

`ifdef FRAME_LOCK_EN
    // lock mid-frame: pulse at hcnt 10, a second absorbed pulse, applied at wrap
    wait_pos(1, 300, 10, 7000);
    pulse_fs_b();
    check("lock_pending_vcnt", s_vcnt, 300);
    wait_pos(1, 300, 15, 100);
    pulse_fs_b();
    wait_pos(1, 300, 19, 100);
    check("lock_no_early_pulse", s_vl, 0);
    step();
    check("lock_vcnt", s_vcnt, 0);
    check("lock_hcnt", s_hcnt, 0);
    check("lock_vlock_adj", s_vl, 1);
    step();
    check("lock_vlock_once", s_vl, 0);
    count_vlock(40, n);
    check("lock_no_repulse", n, 0);
    check("lock_absorbed_vcnt", s_vcnt, 2);

    // coincident pulse at the frame wrap: increment already gives 0
    wait_pos(1, 524, 19, 11000);
    pulse_fs_b();
    check("lock_wrap_vcnt", s_vcnt, 0);
    check("lock_wrap_hcnt", s_hcnt, 0);
    check("lock_wrap_no_vlock", s_vl, 0);
    count_vlock(40, n);
    check("lock_wrap_quiet", n, 0);
    check("lock_wrap_vcnt_after", s_vcnt, 2);
`else
    // frame_start has no effect when frame lock is not built in
    wait_pos(1, 300, 10, 7000);
    pulse_fs_b();
    wait_pos(1, 300, 19, 100);
    pulse_fs_b();
    check("free_vcnt", s_vcnt, 301);
    check("free_hcnt", s_hcnt, 0);
    check("free_vlock", s_vl, 0);
    count_vlock(40, n);
    check("free_vlock_quiet", n, 0);
    check("free_vcnt_after", s_vcnt, 303);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
